ofdm_frame_sequencer: RTL and testbench
=======================================

Name: ofdm_frame_sequencer

Overview:
- Owns the OFDM framer's sync word and sequences each frame as one sync-word symbol followed by N data symbols.
- The sync word loads over an AXI-Stream config port into a shadow register and is committed to the active register only between frames, so a frame never sees a torn sync word.
- Sits between the config DMA / control register file and the framer's symbol mapper, which consumes symbols through a valid/ready handshake.

Parameters:
- USED_CARRIERS, 800, sync word width in bits; must be a multiple of CFG_WIDTH.
- CFG_WIDTH, 32, config stream data width in bits.
- SYMS_W, 8, width of the data-symbol count.

Ports:
- aclk  in  1  single clock
- areset  in  1  asynchronous, active-high reset
- s_axis_config_tdata  in  CFG_WIDTH  sync word chunk, LSB chunk first
- s_axis_config_tvalid  in  1  config beat valid
- s_axis_config_tlast  in  1  marks the final beat of the sync word
- s_axis_config_tready  out  1  config beat accepted
- start  in  1  frame request, sampled in IDLE
- num_data_syms  in  SYMS_W  data symbols per frame, latched at start
- sym_valid  out  1  a symbol slot is offered downstream
- sym_ready  in  1  downstream accepts the slot
- sym_sel  out  1  0 = sync symbol, 1 = data symbol
- frame_last  out  1  high with sym_valid on the final symbol of the frame
- sync_word  out  USED_CARRIERS  active (committed) sync word
- busy  out  1  FSM not in IDLE
- sync_loaded  out  1  at least one commit has occurred since reset
- cfg_error  out  1  one-cycle pulse on a malformed config packet

Behaviour:
- Reset values: state=IDLE; sync_word=0; shadow=0; beat count=0; pending=0; sync_loaded=0; sym_valid=0; sym_sel=0; frame_last=0; busy=0; cfg_error=0; tready=0 while reset is asserted.
- Reset asserted mid-frame or mid-load aborts immediately; the partial frame and partial shadow are discarded.
- Config loader:
  - BEATS = USED_CARRIERS/CFG_WIDTH, which is 25 at the default parameters.
  - tready = !pending && !areset.
  - An accepted beat k (0..BEATS-1) writes shadow[k*CFG_WIDTH +: CFG_WIDTH] and increments the count.
  - tlast on beat k < BEATS-1: pulse cfg_error, count returns to 0, shadow contents are don't-care, pending stays 0.
  - Beat BEATS-1 without tlast: pulse cfg_error, count returns to 0, no pending.
  - Beat BEATS-1 with tlast: pending=1, count=0.
- Commit:
  - When pending=1 and state=IDLE, on that edge sync_word<=shadow, pending<=0 and sync_loaded<=1.
  - A commit never occurs outside IDLE; pending holds, which back-pressures config via tready=0.
- FSM:
  - IDLE: if start && (sync_loaded || commit this cycle), latch n=num_data_syms and go to SYNC. Otherwise start is ignored, with no queuing.
  - Commit and start in the same cycle are both taken; the SYNC symbol uses the newly committed word.
  - SYNC: sym_valid=1, sym_sel=0, frame_last=(n==0). On sym_ready, go to IDLE if n==0, else load remaining=n and go to DATA.
  - DATA: sym_valid=1, sym_sel=1, frame_last=(remaining==1). On sym_ready, decrement remaining; at 1, go to IDLE.
- Handshake:
  - sym_valid, sym_sel and frame_last are registered-state decodes with zero input-to-output latency from state.
  - Once sym_valid is raised, it stays asserted until sym_ready, with outputs stable.
  - Back-to-back frames: IDLE takes a minimum of one cycle between frames, which is the commit window.
  - num_data_syms at its maximum (2^SYMS_W-1) gives 256 symbols per frame at the default widths.
  - start held high re-triggers a frame after each IDLE cycle.

Optional Feature:
- FRAME_COUNT_EN defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments on each completed frame, i.e. the handshake with frame_last=1.
  - Wraps from 16'hFFFF to 0.
- FRAME_COUNT_EN undefined: the port and counter are absent.

Decomposition:
- Package ofdm_framer_pkg:
  - Holds the state enum (IDLE, SYNC, DATA).
  - Holds the function cfg_beats(width, carriers), which returns carriers/width.
  - Holds the parameter legality check (USED_CARRIERS % CFG_WIDTH == 0).
- Sub-module sync_word_shadow:
  - Contains the config loader, beat counter, shadow register and pending flag.
  - Exposes pending, shadow and commit.
- The sequencer FSM and the active register remain in the top level.

Test Plan:
- Load 25 beats, data 32'h0+k, tlast on beat 24 → pending, commit on the next IDLE edge, sync_word[k*32+:32]==k, sync_loaded=1, no cfg_error.
- tlast on beat 10 → cfg_error pulses one cycle; sync_word unchanged; a following full 25-beat load commits correctly.
- start with num_data_syms=3 and sym_ready always 1 → sym_sel sequence 0,1,1,1 on 4 consecutive cycles, frame_last on the 4th, busy for 4 cycles.
- num_data_syms=0 → single SYNC symbol with frame_last=1; return to IDLE.
- Reload finishes mid-frame (sym_ready toggling 50%) → tready=0 while pending; sync_word constant until IDLE; the next frame uses the new word.
- start before any load → ignored, sym_valid stays 0. Assert areset during DATA → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ofdm_framer_pkg.sv
// Shared types and helpers for the OFDM frame sequencer: state encoding,
// config beat count and the parameter legality check.
package ofdm_framer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } seq_state_e;

  function automatic int unsigned cfg_beats(input int unsigned width,
                                            input int unsigned carriers);
    return carriers / width;
  endfunction

  // Sync word must split into a whole, non-zero number of config beats.
  function automatic bit cfg_params_ok(input int unsigned width,
                                       input int unsigned carriers);
    return (width != 0) && (carriers >= width) && ((carriers % width) == 0);
  endfunction

endpackage

// File: rtl/sync_word_shadow.sv
// Config-stream loader: assembles the sync word into a shadow register and
// holds it pending until the sequencer is idle and can commit it.
module sync_word_shadow
  import ofdm_framer_pkg::*;
#(
  parameter int unsigned CARRIERS = 800,
  parameter int unsigned CFG_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_W-1:0]    tdata,
  input  logic                tvalid,
  input  logic                tlast,
  output logic                tready,
  input  logic                idle,
  output logic                pending,
  output logic [CARRIERS-1:0] shadow,
  output logic                commit,
  output logic                cfg_error
);

  localparam int unsigned BEATS = cfg_beats(CFG_W, CARRIERS);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CARRIERS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                err_q, err_d;
  logic                accept;

  assign tready = !pending_q && !rst;
  assign accept = tvalid && tready;
  assign commit = pending_q && idle;

  // Beat placement and packet framing checks.
  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    if (commit) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d[32'(cnt_q) * CFG_W +: CFG_W] = tdata;
      if (cnt_q == LAST_BEAT) begin
        cnt_d = '0;
        if (tlast) begin
          pending_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (tlast) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending   = pending_q;
  assign shadow    = shadow_q;
  assign cfg_error = err_q;

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// Sequences each OFDM frame as one sync symbol plus N data symbols and owns
// the committed sync word. Define FRAME_COUNT_EN to add the frame_count output.
module ofdm_frame_sequencer
  import ofdm_framer_pkg::*;
#(
  parameter int unsigned USED_CARRIERS = 800,
  parameter int unsigned CFG_WIDTH     = 32,
  parameter int unsigned SYMS_W        = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [CFG_WIDTH-1:0]     s_axis_config_tdata,
  input  logic                     s_axis_config_tvalid,
  input  logic                     s_axis_config_tlast,
  output logic                     s_axis_config_tready,
  input  logic                     start,
  input  logic [SYMS_W-1:0]        num_data_syms,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     sym_sel,
  output logic                     frame_last,
  output logic [USED_CARRIERS-1:0] sync_word,
  output logic                     busy,
  output logic                     sync_loaded,
`ifdef FRAME_COUNT_EN
  output logic [15:0]              frame_count,
`endif
  output logic                     cfg_error
);

  if (!cfg_params_ok(CFG_WIDTH, USED_CARRIERS)) begin : g_bad_params
    $error("USED_CARRIERS must be a non-zero multiple of CFG_WIDTH");
  end

  seq_state_e               state_q, state_d;
  logic [SYMS_W-1:0]        n_q, n_d;
  logic [SYMS_W-1:0]        rem_q, rem_d;
  logic [USED_CARRIERS-1:0] sync_word_q, sync_word_d;
  logic                     sync_loaded_q, sync_loaded_d;
  logic                     sym_valid_q, sym_valid_d;
  logic                     sym_sel_q, sym_sel_d;
  logic                     frame_last_q, frame_last_d;
  logic                     busy_q, busy_d;
  logic                     pending;
  logic                     commit;
  logic [USED_CARRIERS-1:0] shadow;

  sync_word_shadow #(
    .CARRIERS (USED_CARRIERS),
    .CFG_W    (CFG_WIDTH)
  ) u_shadow (
    .clk       (aclk),
    .rst       (areset),
    .tdata     (s_axis_config_tdata),
    .tvalid    (s_axis_config_tvalid),
    .tlast     (s_axis_config_tlast),
    .tready    (s_axis_config_tready),
    .idle      (state_q == IDLE),
    .pending   (pending),
    .shadow    (shadow),
    .commit    (commit),
    .cfg_error (cfg_error)
  );

  // Frame FSM; symbol outputs are registered from the next state so they
  // track the state register with no extra latency.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    rem_d         = rem_q;
    sync_word_d   = sync_word_q;
    sync_loaded_d = sync_loaded_q;
    if (commit) begin
      sync_word_d   = shadow;
      sync_loaded_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start && (sync_loaded_q || commit)) begin
          n_d     = num_data_syms;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (sym_ready) begin
          if (n_q == '0) begin
            state_d = IDLE;
          end else begin
            rem_d   = n_q;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sym_ready) begin
          if (rem_q == SYMS_W'(1)) begin
            state_d = IDLE;
          end else begin
            rem_d = rem_q - SYMS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sym_valid_d  = (state_d != IDLE);
    sym_sel_d    = (state_d == DATA);
    frame_last_d = ((state_d == SYNC) && (n_d == '0)) ||
                   ((state_d == DATA) && (rem_d == SYMS_W'(1)));
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      rem_q         <= '0;
      sync_word_q   <= '0;
      sync_loaded_q <= 1'b0;
      sym_valid_q   <= 1'b0;
      sym_sel_q     <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      rem_q         <= rem_d;
      sync_word_q   <= sync_word_d;
      sync_loaded_q <= sync_loaded_d;
      sym_valid_q   <= sym_valid_d;
      sym_sel_q     <= sym_sel_d;
      frame_last_q  <= frame_last_d;
      busy_q        <= busy_d;
    end
  end

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (sym_valid_q && sym_ready && frame_last_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign sym_valid   = sym_valid_q;
  assign sym_sel     = sym_sel_q;
  assign frame_last  = frame_last_q;
  assign sync_word   = sync_word_q;
  assign busy        = busy_q;
  assign sync_loaded = sync_loaded_q;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Self-checking bench for ofdm_frame_sequencer against a transaction-level
// model of the sync word and frame symbol sequence.
module tb_ofdm_frame_sequencer;

  localparam int unsigned CARR  = 800;
  localparam int unsigned CW    = 32;
  localparam int unsigned SW    = 8;
  localparam int unsigned BEATS = CARR / CW;

  logic            aclk;
  logic            areset;
  logic [CW-1:0]   cfg_tdata;
  logic            cfg_tvalid;
  logic            cfg_tlast;
  logic            cfg_tready;
  logic            start;
  logic [SW-1:0]   num_data_syms;
  logic            sym_valid;
  logic            sym_ready;
  logic            sym_sel;
  logic            frame_last;
  logic [CARR-1:0] sync_word;
  logic            busy;
  logic            sync_loaded;
  logic            cfg_error;
`ifdef FRAME_COUNT_EN
  logic [15:0]     frame_count;
`endif

  ofdm_frame_sequencer #(
    .USED_CARRIERS (CARR),
    .CFG_WIDTH     (CW),
    .SYMS_W        (SW)
  ) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tlast  (cfg_tlast),
    .s_axis_config_tready (cfg_tready),
    .start                (start),
    .num_data_syms        (num_data_syms),
    .sym_valid            (sym_valid),
    .sym_ready            (sym_ready),
    .sym_sel              (sym_sel),
    .frame_last           (frame_last),
    .sync_word            (sync_word),
    .busy                 (busy),
    .sync_loaded          (sync_loaded),
`ifdef FRAME_COUNT_EN
    .frame_count          (frame_count),
`endif
    .cfg_error            (cfg_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [CARR-1:0] model_sync;
  int              model_frames;

  int   err_pulses = 0;
  int   err_long   = 0;
  logic err_prev   = 1'b0;

  always @(negedge aclk) begin
    if (cfg_error === 1'b1) begin
      err_pulses++;
      if (err_prev === 1'b1) err_long++;
    end
    err_prev = cfg_error;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [CW-1:0] d, input logic last);
    int waits;
    waits = 0;
    cfg_tdata  = d;
    cfg_tvalid = 1'b1;
    cfg_tlast  = last;
    while (cfg_tready !== 1'b1 && waits < 2000) begin
      @(negedge aclk);
      waits++;
    end
    if (cfg_tready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout tready=%b required=1", cfg_tready);
    end
    @(posedge aclk);
    @(negedge aclk);
    cfg_tvalid = 1'b0;
    cfg_tlast  = 1'b0;
  endtask

  task automatic load_packet(input int len, input int tlast_at, input bit incr,
                             output logic [CARR-1:0] w);
    logic [CW-1:0] d;
    w = '0;
    for (int k = 0; k < len; k++) begin
      d = incr ? CW'(k) : CW'($urandom);
      w[k*CW +: CW] = d;
      send_beat(d, 1'(k == tlast_at));
    end
  endtask

  // One frame of n data symbols; expected sequence is SYNC then n DATA.
  task automatic run_frame(input int n, input bit always_ready);
    int idx, cyc, total;
    total = n + 1;
    idx   = 0;
    cyc   = 0;
    start = 1'b1;
    num_data_syms = SW'(n);
    @(posedge aclk);
    @(negedge aclk);
    start = 1'b0;
    while (idx < total && cyc < 4 * total + 50) begin
      checks++;
      if ({sym_valid, sym_sel, frame_last, busy} !==
          {1'b1, 1'(idx != 0), 1'(idx == total - 1), 1'b1}) begin
        errors++;
        $display("FAIL frame_sym n=%0d idx=%0d got v/sel/last/busy=%b%b%b%b required=1%b%b1",
                 n, idx, sym_valid, sym_sel, frame_last, busy, idx != 0, idx == total - 1);
      end
      checks++;
      if (sync_word !== model_sync) begin
        errors++;
        $display("FAIL frame_sync_word low64 got %h required %h", sync_word[63:0], model_sync[63:0]);
      end
      sym_ready = always_ready ? 1'b1 : 1'($urandom % 2);
      @(posedge aclk);
      if (sym_ready) idx++;
      cyc++;
      @(negedge aclk);
    end
    sym_ready = 1'b0;
    checks++;
    if (idx != total) begin
      errors++;
      $display("FAIL frame_timeout n=%0d symbols got %0d required %0d", n, idx, total);
    end
    if (always_ready) begin
      checks++;
      if (cyc != total) begin
        errors++;
        $display("FAIL frame_busy_cycles got %0d required %0d", cyc, total);
      end
    end
    checks++;
    if ({sym_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL frame_end_idle got v/busy=%b%b required 00", sym_valid, busy);
    end
    model_frames++;
`ifdef FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'(model_frames)) begin
      errors++;
      $display("FAIL frame_count got %0d required %0d", frame_count, model_frames);
    end
`endif
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cfg_tdata = '0; cfg_tvalid = 1'b0; cfg_tlast = 1'b0;
    start = 1'b0; num_data_syms = '0; sym_ready = 1'b0;
    model_sync = '0;
    model_frames = 0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({sym_valid, sym_sel, frame_last, busy, sync_loaded, cfg_error, cfg_tready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0000000",
               {sym_valid, sym_sel, frame_last, busy, sync_loaded, cfg_error, cfg_tready});
    end
    checks++;
    if (sync_word !== '0) begin
      errors++;
      $display("FAIL reset_sync_word low64 got %h required 0", sync_word[63:0]);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (cfg_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready got %b required 1", cfg_tready);
    end
  endtask

  task automatic test_start_unloaded();
    start = 1'b1;
    num_data_syms = SW'($urandom);
    repeat (6) begin
      @(negedge aclk);
      checks++;
      if ({sym_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL start_unloaded got v/busy=%b%b required 00", sym_valid, busy);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_load_full(input bit incr);
    logic [CARR-1:0] w;
    int e0;
    e0 = err_pulses;
    load_packet(BEATS, BEATS - 1, incr, w);
    checks++;
    if (cfg_tready !== 1'b0 || sync_word !== model_sync) begin
      errors++;
      $display("FAIL load_pending tready=%b required 0, low64 %h required %h",
               cfg_tready, sync_word[63:0], model_sync[63:0]);
    end
    @(negedge aclk);
    model_sync = w;
    checks++;
    if (sync_word !== model_sync) begin
      errors++;
      $display("FAIL load_commit low64 got %h required %h", sync_word[63:0], model_sync[63:0]);
    end
    checks++;
    if ({sync_loaded, cfg_tready} !== 2'b11 || err_pulses != e0) begin
      errors++;
      $display("FAIL load_status loaded/tready=%b%b required 11, cfg_error pulses %0d required 0",
               sync_loaded, cfg_tready, err_pulses - e0);
    end
  endtask

  task automatic test_bad_packets();
    logic [CARR-1:0] w;
    int e0, len, tl;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       begin len = 11;    tl = 10; end
        1:       begin len = BEATS; tl = -1; end
        default: begin len = $urandom_range(1, BEATS - 1); tl = len - 1; end
      endcase
      e0 = err_pulses;
      load_packet(len, tl, 1'b0, w);
      repeat (2) @(negedge aclk);
      checks++;
      if (err_pulses - e0 != 1) begin
        errors++;
        $display("FAIL bad_pkt_error case=%0d pulses got %0d required 1", c, err_pulses - e0);
      end
      checks++;
      if (sync_word !== model_sync || cfg_tready !== 1'b1) begin
        errors++;
        $display("FAIL bad_pkt_word case=%0d tready=%b low64 %h required %h",
                 c, cfg_tready, sync_word[63:0], model_sync[63:0]);
      end
    end
    test_load_full(1'b0);
  endtask

  task automatic test_frames();
    run_frame(3, 1'b1);
    run_frame(0, 1'b1);
    run_frame(255, 1'b1);
    repeat (4) run_frame($urandom_range(0, 12), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_q[$];
    int n0, n1;
    n0 = $urandom_range(0, 4);
    n1 = $urandom_range(1, 5);
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back({1'b1, 1'b0, 1'((f == 0 ? n0 : n1) == 0)});
      for (int j = 1; j <= (f == 0 ? n0 : n1); j++)
        exp_q.push_back({1'b1, 1'b1, 1'(j == (f == 0 ? n0 : n1))});
      if (f == 0) exp_q.push_back(3'b000);
    end
    sym_ready = 1'b1;
    start = 1'b1;
    num_data_syms = SW'(n0);
    @(posedge aclk);
    @(negedge aclk);
    num_data_syms = SW'(n1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({sym_valid, sym_sel, frame_last} !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b cycle=%0d got v/sel/last=%b required %b",
                 i, {sym_valid, sym_sel, frame_last}, exp_q[i]);
      end
      if (i == exp_q.size() - 1) start = 1'b0;
      @(negedge aclk);
    end
    repeat (2) begin
      checks++;
      if ({sym_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_end got v/busy=%b%b required 00", sym_valid, busy);
      end
      @(negedge aclk);
    end
    sym_ready = 1'b0;
    model_frames += 2;
  endtask

  task automatic test_reload_mid_frame();
    logic [CARR-1:0] w;
    logic [CW-1:0] d;
    w = '0;
    for (int k = 0; k < 20; k++) begin
      d = CW'($urandom);
      w[k*CW +: CW] = d;
      send_beat(d, 1'b0);
    end
    fork
      run_frame(20, 1'b0);
      begin
        int guard;
        logic [CW-1:0] d2;
        for (int k = 20; k < BEATS; k++) begin
          d2 = CW'($urandom);
          w[k*CW +: CW] = d2;
          send_beat(d2, 1'(k == BEATS - 1));
        end
        guard = 0;
        while (busy === 1'b1 && guard < 500) begin
          checks++;
          if (cfg_tready !== 1'b0) begin
            errors++;
            $display("FAIL reload_backpressure tready got %b required 0", cfg_tready);
          end
          guard++;
          @(negedge aclk);
        end
      end
    join
    checks++;
    if (cfg_tready !== 1'b0 || sync_word !== model_sync) begin
      errors++;
      $display("FAIL reload_pre_commit tready=%b required 0, low64 %h required %h",
               cfg_tready, sync_word[63:0], model_sync[63:0]);
    end
    @(negedge aclk);
    model_sync = w;
    checks++;
    if (cfg_tready !== 1'b1 || sync_word !== model_sync) begin
      errors++;
      $display("FAIL reload_commit tready=%b required 1, low64 %h required %h",
               cfg_tready, sync_word[63:0], model_sync[63:0]);
    end
    run_frame($urandom_range(1, 5), 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    num_data_syms = SW'(10);
    sym_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    start = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({sym_valid, sym_sel} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_data got v/sel=%b%b required 11", sym_valid, sym_sel);
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({sym_valid, sym_sel, frame_last, busy, sync_loaded, cfg_error, cfg_tready} !== 7'b0
        || sync_word !== '0) begin
      errors++;
      $display("FAIL async_reset got %b required 0000000, low64 %h required 0",
               {sym_valid, sym_sel, frame_last, busy, sync_loaded, cfg_error, cfg_tready},
               sync_word[63:0]);
    end
    @(negedge aclk);
    areset = 1'b0;
    sym_ready = 1'b0;
    model_sync = '0;
    model_frames = 0;
`ifdef FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count got %0d required 0", frame_count);
    end
`endif
    test_start_unloaded();
    // Partial load interrupted by reset must not skew the next packet.
    for (int k = 0; k < 5; k++) send_beat(CW'($urandom), 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    test_load_full(1'b0);
    run_frame($urandom_range(0, 6), 1'b0);
  endtask

  initial begin
    test_reset();
    test_start_unloaded();
    test_load_full(1'b1);
    test_bad_packets();
    test_frames();
    test_back_to_back();
    test_reload_mid_frame();
    test_reset_mid_frame();
    checks++;
    if (err_long != 0) begin
      errors++;
      $display("FAIL cfg_error_width multi-cycle pulses got %0d required 0", err_long);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
